// File: rtl/miriscv_gpr_pkg.sv
// Defaults and types for the multi-port general-purpose register file.
package miriscv_gpr_pkg;
   localparam int GPR_ADDR_WIDTH  = 5;
   localparam int GPR_NUM_RD      = 2;
   localparam int GPR_NUM_WR      = 2;
   localparam int GPR_BYPASS_EN   = 1;
   localparam int GPR_ZERO_REG_EN = 1;

   typedef logic [GPR_ADDR_WIDTH-1:0] gpr_addr_t;
endpackage

// File: rtl/miriscv_pkg.sv
// Core-wide constants shared by the miriscv pipeline stages.
package miriscv_pkg;
   localparam int XLEN = 32;
endpackage

// File: rtl/miriscv_gpr_mp_if.sv
// Register-file access bundle: write ports, read ports and scoreboard controls.
interface miriscv_gpr_mp_if
   import miriscv_gpr_pkg::*;
#(
   parameter int DATA_WIDTH = miriscv_pkg::XLEN,
   parameter int ADDR_WIDTH = GPR_ADDR_WIDTH,
   parameter int NUM_RD     = GPR_NUM_RD,
   parameter int NUM_WR     = GPR_NUM_WR
);
   logic [NUM_WR-1:0]                 wr_en_i;
   logic [NUM_WR-1:0][ADDR_WIDTH-1:0] wr_addr_i;
   logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data_i;
   logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_addr_i;
   logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data_o;
   logic [NUM_RD-1:0]                 rd_busy_o;
   logic                              sb_set_i;
   logic [ADDR_WIDTH-1:0]             sb_set_addr_i;
   logic                              sb_flush_i;
   logic [(2**ADDR_WIDTH)-1:0]        busy_vec_o;

   modport master (
      output wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, sb_set_i, sb_set_addr_i, sb_flush_i,
      input  rd_data_o, rd_busy_o, busy_vec_o
   );
   modport slave (
      input  wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, sb_set_i, sb_set_addr_i, sb_flush_i,
      output rd_data_o, rd_busy_o, busy_vec_o
   );
endinterface

// File: rtl/miriscv_gpr_sb.sv
// Per-register busy scoreboard: flush beats set, set beats writeback clear.
module miriscv_gpr_sb
   import miriscv_gpr_pkg::*;
#(
   parameter int ADDR_WIDTH  = GPR_ADDR_WIDTH,
   parameter int ZERO_REG_EN = GPR_ZERO_REG_EN
) (
   input  logic                       clk_i,
   input  logic                       arstn_i,
   input  logic                       set,
   input  logic [ADDR_WIDTH-1:0]      set_addr,
   input  logic                       flush,
   input  logic [(2**ADDR_WIDTH)-1:0] clr,
   output logic [(2**ADDR_WIDTH)-1:0] busy
);
   localparam int NUM_WORDS = 2**ADDR_WIDTH;
   localparam bit ZR        = (ZERO_REG_EN != 0);

   logic [NUM_WORDS-1:0] busy_nxt;

   always_comb begin
      busy_nxt = busy;
      if (flush) begin
         busy_nxt = '0;
      end else begin
         for (int r = 0; r < NUM_WORDS; r++) begin
            if (set && (set_addr == ADDR_WIDTH'(r)) && !(ZR && r == 0))
               busy_nxt[r] = 1'b1;
            else if (clr[r])
               busy_nxt[r] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) busy <= '0;
      else          busy <= busy_nxt;
   end
endmodule

// File: rtl/miriscv_gpr_mp.sv
// Multi-port GPR file: N reads, M writes (highest port wins), optional bypass, busy scoreboard.
module miriscv_gpr_mp
   import miriscv_gpr_pkg::*;
#(
   parameter int DATA_WIDTH  = miriscv_pkg::XLEN,
   parameter int ADDR_WIDTH  = GPR_ADDR_WIDTH,
   parameter int NUM_RD      = GPR_NUM_RD,
   parameter int NUM_WR      = GPR_NUM_WR,
   parameter int BYPASS_EN   = GPR_BYPASS_EN,
   parameter int ZERO_REG_EN = GPR_ZERO_REG_EN
) (
   input  logic             clk_i,
   input  logic             arstn_i,
   miriscv_gpr_mp_if.slave  bus
);
   localparam int NUM_WORDS = 2**ADDR_WIDTH;
   localparam bit BYP       = (BYPASS_EN != 0);
   localparam bit ZR        = (ZERO_REG_EN != 0);

   if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_rd
      $error("miriscv_gpr_mp: NUM_RD=%0d outside 1..4", NUM_RD);
   end
   if (NUM_WR < 1 || NUM_WR > 4) begin : g_bad_wr
      $error("miriscv_gpr_mp: NUM_WR=%0d outside 1..4", NUM_WR);
   end

   logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] mem;
   logic [NUM_WORDS-1:0]                 wr_hit;
   logic [NUM_WORDS-1:0]                 busy;
   logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_data;
   logic [NUM_RD-1:0]                    rd_busy;

   always_comb begin
      wr_hit = '0;
      for (int k = 0; k < NUM_WR; k++)
         if (bus.wr_en_i[k]) wr_hit[bus.wr_addr_i[k]] = 1'b1;
   end

   // Ascending port order: the last non-blocking write to an address is the highest port.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         mem <= '0;
      end else begin
         for (int k = 0; k < NUM_WR; k++)
            if (bus.wr_en_i[k] && !(ZR && bus.wr_addr_i[k] == '0))
               mem[bus.wr_addr_i[k]] <= bus.wr_data_i[k];
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int j = 0; j < NUM_RD; j++) begin
         rd_data[j] = mem[bus.rd_addr_i[j]];
         rd_busy[j] = busy[bus.rd_addr_i[j]] & ~(BYP & wr_hit[bus.rd_addr_i[j]]);
         if (BYP) begin
            for (int k = 0; k < NUM_WR; k++)
               if (bus.wr_en_i[k] && bus.wr_addr_i[k] == bus.rd_addr_i[j])
                  rd_data[j] = bus.wr_data_i[k];
         end
         if (ZR && bus.rd_addr_i[j] == '0) begin
            rd_data[j] = '0;
            rd_busy[j] = 1'b0;
         end
      end
   end

   assign bus.rd_data_o  = rd_data;
   assign bus.rd_busy_o  = rd_busy;
   assign bus.busy_vec_o = busy;

   miriscv_gpr_sb #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .ZERO_REG_EN (ZERO_REG_EN)
   ) u_sb (
      .clk_i    (clk_i),
      .arstn_i  (arstn_i),
      .set      (bus.sb_set_i),
      .set_addr (bus.sb_set_addr_i),
      .flush    (bus.sb_flush_i),
      .clr      (wr_hit),
      .busy     (busy)
   );
endmodule

// File: doc/miriscv_gpr_mp.md
Name: miriscv_gpr_mp

Overview:
Parametrised multi-port general-purpose register file for the miriscv core. It supports N read ports and M write ports, optional write-to-read bypass, and a per-register busy scoreboard. Decode uses the scoreboard to stall on RAW hazards against multi-cycle or out-of-order writebacks. It replaces the single-write, dual-read GPR in the decode/writeback stages.

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register address width; NUM_WORDS = 2**ADDR_WIDTH
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..4)
BYPASS_EN, 1, 1 = same-cycle write data is forwarded to reads
ZERO_REG_EN, 1, 1 = register 0 is hardwired to zero and is never busy

Ports:
clk_i  in  1  core clock
arstn_i  in  1  asynchronous reset, active-low
wr_en_i  in  NUM_WR  per-port write enable
wr_addr_i  in  NUM_WR*ADDR_WIDTH  write addresses; port k uses slice k
wr_data_i  in  NUM_WR*DATA_WIDTH  write data; port k uses slice k
rd_addr_i  in  NUM_RD*ADDR_WIDTH  read addresses
rd_data_o  out  NUM_RD*DATA_WIDTH  read data, combinational
rd_busy_o  out  NUM_RD  register at rd_addr is pending writeback
sb_set_i  in  1  issue: mark sb_set_addr_i busy
sb_set_addr_i  in  ADDR_WIDTH  destination register of issued instruction
sb_flush_i  in  1  clear all busy bits (pipeline flush)
busy_vec_o  out  NUM_WORDS  raw scoreboard state

Behaviour:
- Reset (arstn_i low, asynchronous): all registers = 0 and all busy bits = 0. Consequently rd_data_o = 0, rd_busy_o = 0 and busy_vec_o = 0 while reset is held. Reset mid-write discards the write.
- Write: on posedge clk_i, each port k with wr_en_i[k]=1 writes its data. Write latency is 1 cycle.
- Write collision: if several enabled ports target the same address, the highest port index wins.
- Zero register: with ZERO_REG_EN=1, writes to address 0 are dropped, reads of address 0 return 0, rd_busy_o=0 for address 0, and sb_set to address 0 is ignored. With ZERO_REG_EN=0, address 0 is an ordinary register.
- Read: rd_data_o[j] is combinational from rd_addr_i[j].
  - BYPASS_EN=1: if any enabled write port targets rd_addr_i[j] this cycle, the data of the highest such port index is returned (0 for x0 with ZERO_REG_EN).
  - BYPASS_EN=0: the stored value is returned; the new value is visible the cycle after the write.
- Scoreboard, per-register busy bit b[r], next-state on posedge:
  - sb_flush_i=1 → all b = 0. Flush has the highest priority and overrides sb_set_i in the same cycle.
  - Otherwise set_r = sb_set_i & (sb_set_addr_i==r) and clr_r = any enabled write to r.
  - set_r → b[r]=1. Set beats clear on the same register in the same cycle (an old producer retires while a new one issues).
  - else clr_r → b[r]=0.
  - else hold.
- rd_busy_o[j] = b[rd_addr_i[j]] & ~(BYPASS_EN & clr at rd_addr_i[j] this cycle). With bypass, a consumer reading in the writeback cycle is not stalled; without bypass it is stalled for that cycle.
- busy_vec_o = b (registered state, no bypass masking).
- A write to a non-busy register is legal; the scoreboard stays 0.
- Multiple reads of the same address on different ports return identical data and busy.
- Illegal parameter values (NUM_RD or NUM_WR outside 1..4) are rejected at elaboration with $error.

Decomposition:
- Package miriscv_gpr_pkg gains GPR_NUM_RD, GPR_NUM_WR and GPR_BYPASS_EN defaults, plus a gpr_addr_t typedef (logic [GPR_ADDR_WIDTH-1:0]).
- XLEN from miriscv_pkg is the DATA_WIDTH default at instantiation.
- One sub-module, miriscv_gpr_sb: the busy-bit scoreboard (set/clear/flush priority logic, busy_vec_o). The storage, write-priority mux and bypass logic stay in the top module.

Test Plan:
1. Reset then read: hold arstn_i low, drive rd_addr 3 and 31 → rd_data 0, rd_busy 0, busy_vec 0; release reset, same addresses → still 0.
2. Write collision: wr_en=2'b11, both ports address 5, data 0xAAAA_0001 (port 0) and 0xBBBB_0002 (port 1) → same-cycle bypass read of 5 = 0xBBBB_0002; next cycle stored value = 0xBBBB_0002.
3. Bypass off: BYPASS_EN=0, write 0x1234 to x7 → same-cycle read of x7 returns old value 0; next cycle returns 0x1234.
4. Zero register: write 0xFFFF_FFFF to x0 and sb_set to x0 → read x0 = 0, busy_vec[0] = 0.
5. Scoreboard: sb_set x9, next cycle read x9 → rd_busy=1. Then write x9 with BYPASS_EN=1 → rd_busy=0 in that cycle and busy_vec[9]=0 the cycle after. Repeat with sb_set x9 coinciding with the write → busy_vec[9]=1 afterwards.
6. Flush and async reset: set x1, x2, x3 busy, assert sb_flush_i together with sb_set x4 → busy_vec all 0 next cycle. Set x6, then drop arstn_i mid-cycle → busy_vec and x6 data clear immediately, without waiting for a clock edge.
